// File: rtl/alu_uart_sequencer.sv
// Frame sequencer between a UART byte stream and the ALU: captures operand 1, opcode and
// operand 2, waits out the ALU latency, then hands the result to the UART transmitter.
module alu_uart_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OPCODE      = 6,
    parameter int ALU_LATENCY    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_tx_done,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic [NB_DATA-1:0]   o_operando_1,
    output logic [NB_DATA-1:0]   o_operando_2,
    output logic [NB_OPCODE-1:0] o_opcode,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic                 o_timeout,
    output logic                 o_overrun
);

    localparam int NB_LAT = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;
    localparam int NB_TMO = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [NB_LAT-1:0] LAT_LAST = NB_LAT'(ALU_LATENCY - 1);
    localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OP1,
        S_OPCODE,
        S_OP2,
        S_EXEC,
        S_TX_WAIT
    } state_t;

    state_t              r_state;
    logic [NB_LAT-1:0]   r_lat_cnt;
    logic [NB_TMO-1:0]   r_tmo_cnt;
    logic [NB_DATA-1:0]  r_operando_1;
    logic [NB_DATA-1:0]  r_operando_2;
    logic [NB_OPCODE-1:0] r_opcode;
    logic [NB_DATA-1:0]  r_tx_data;
    logic                r_tx_start;
    logic                r_busy;
    logic                r_timeout;
    logic                r_overrun;

    logic w_tmo_hit;
    logic w_lat_hit;

    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
    assign w_lat_hit = (r_lat_cnt == LAT_LAST);

    // Upper bits of the opcode byte are deliberately discarded.
    generate
        if (NB_DATA > NB_OPCODE) begin : g_opcode_trunc
            logic w_unused_rx_hi;
            assign w_unused_rx_hi = ^i_rx_data[NB_DATA-1:NB_OPCODE];
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_OP1;
            r_lat_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_operando_1 <= '0;
            r_operando_2 <= '0;
            r_opcode     <= '0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
            case (r_state)
                S_OP1: begin
                    if (i_rx_done) begin
                        r_operando_1 <= i_rx_data;
                        r_tmo_cnt    <= '0;
                        r_state      <= S_OPCODE;
                    end
                end
                S_OPCODE: begin
                    if (i_rx_done) begin
                        r_opcode  <= i_rx_data[NB_OPCODE-1:0];
                        r_tmo_cnt <= '0;
                        r_state   <= S_OP2;
                    end else if (w_tmo_hit) begin
                        r_tmo_cnt <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= S_OP1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_OP2: begin
                    if (i_rx_done) begin
                        r_operando_2 <= i_rx_data;
                        r_tmo_cnt    <= '0;
                        r_lat_cnt    <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_EXEC;
                    end else if (w_tmo_hit) begin
                        r_tmo_cnt <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= S_OP1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    r_overrun <= i_rx_done;
                    if (w_lat_hit) begin
                        r_tx_data  <= i_alu_result;
                        r_tx_start <= 1'b1;
                        r_state    <= S_TX_WAIT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                S_TX_WAIT: begin
                    if (i_tx_done) begin
                        r_busy <= 1'b0;
                        if (i_rx_done) begin
                            r_operando_1 <= i_rx_data;
                            r_tmo_cnt    <= '0;
                            r_state      <= S_OPCODE;
                        end else begin
                            r_state <= S_OP1;
                        end
                    end else begin
                        r_overrun <= i_rx_done;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_OP1;
                end
            endcase
        end
    end

    assign o_operando_1 = r_operando_1;
    assign o_operando_2 = r_operando_2;
    assign o_opcode     = r_opcode;
    assign o_tx_data    = r_tx_data;
    assign o_tx_start   = r_tx_start;
    assign o_busy       = r_busy;
    assign o_timeout    = r_timeout;
    assign o_overrun    = r_overrun;

endmodule
